// File: rtl/code_fetch_unit.sv
// code_fetch_unit: instruction fetch sequencer for a 1-cycle-latency
// synchronous-read code memory. Owns the PC, drives the memory address and
// presents a valid/ready instruction stream to the core at one instruction
// per cycle when unstalled. Accepts PC redirects and halt requests.
//
// Optional build macro: FETCH_PERF_EN adds two 16-bit saturating performance
// counters (fired instructions, stall cycles). Without it both counter ports
// are tied to zero and no counter flops exist.
//
// Handshake: instr_valid/instr_ready follow strict valid/ready semantics. A
// transfer (fire) happens on a rising edge where both are high. While
// instr_valid is high and instr_ready is low, instr_data and instr_pc are held
// stable until the transfer. The only way a presented instruction disappears
// without firing is a redirect, which squashes it by forcing instr_valid low.
module code_fetch_unit #(
    parameter int unsigned       ADDR_W   = 9,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    // Code memory side
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    // Instruction stream to the core
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    // Control from the core
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              busy,
    // Performance counters (zero unless FETCH_PERF_EN)
    output logic [15:0]       perf_instr_cnt,
    output logic [15:0]       perf_stall_cnt,
    // Debug view of the sequencer state
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [ADDR_W-1:0] addr_sel;

    logic fire;
    logic stall;
    logic may_issue;

    // The pending word is always the one on mem_data; a redirect squashes it.
    assign instr_valid = pend_valid_q & ~redirect_valid;
    assign instr_data  = mem_data;
    assign instr_pc    = pend_pc_q;
    assign busy        = pend_valid_q;
    assign dbg_state   = state_q;

    assign fire      = instr_valid & instr_ready;
    assign stall     = pend_valid_q & ~instr_ready & ~redirect_valid;
    assign may_issue = (state_q == S_RUN) & ~halt;

    // While in reset the memory is pointed at the restart address so the
    // first word is already being read when reset releases.
    assign mem_addr = rst_n ? addr_sel : RESET_PC;

    // Next fetch/pending state and memory address, in priority order:
    // redirect, stall (re-read pending address), issue, idle/drain.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        addr_sel     = fetch_pc_q;
        if (redirect_valid) begin
            if (may_issue) begin
                addr_sel     = redirect_pc;
                pend_valid_d = 1'b1;
                pend_pc_d    = redirect_pc;
                fetch_pc_d   = redirect_pc + 1'b1;
            end else begin
                addr_sel     = redirect_pc;
                fetch_pc_d   = redirect_pc;
                pend_valid_d = 1'b0;
            end
        end else if (stall) begin
            // Re-read the pending address so mem_data stays stable.
            addr_sel = pend_pc_q;
        end else if (may_issue) begin
            addr_sel     = fetch_pc_q;
            pend_valid_d = 1'b1;
            pend_pc_d    = fetch_pc_q;
            fetch_pc_d   = fetch_pc_q + 1'b1;
        end else begin
            addr_sel     = fetch_pc_q;
            pend_valid_d = pend_valid_q & ~fire;
        end
    end

    // Sequencer registers and run/drain/halted state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            fetch_pc_q   <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            case (state_q)
                S_RUN: begin
                    // Drain only if a fetched word survives this cycle.
                    if (halt) begin
                        state_q <= pend_valid_d ? S_DRAIN : S_HALTED;
                    end
                end
                S_DRAIN: begin
                    if (fire || redirect_valid) begin
                        state_q <= S_HALTED;
                    end else if (!halt) begin
                        state_q <= S_RUN;
                    end
                end
                S_HALTED: begin
                    if (!halt) begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] perf_instr_cnt_q;
    logic [15:0] perf_stall_cnt_q;

    // Saturating counters of fired instructions and stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_instr_cnt_q <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            if (fire && (perf_instr_cnt_q != 16'hFFFF)) begin
                perf_instr_cnt_q <= perf_instr_cnt_q + 16'd1;
            end
            if (stall && (perf_stall_cnt_q != 16'hFFFF)) begin
                perf_stall_cnt_q <= perf_stall_cnt_q + 16'd1;
            end
        end
    end

    assign perf_instr_cnt = perf_instr_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`else
    assign perf_instr_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_code_fetch_unit.sv
// Testbench for code_fetch_unit: table-driven cycle vectors followed by
// hand-written sequences for mid-stream reset, redirect squash and counters.
module tb_code_fetch_unit;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;

`ifdef FETCH_PERF_EN
    localparam logic [15:0] EXP_INSTR_CNT = 16'd20;
    localparam logic [15:0] EXP_STALL_CNT = 16'd3;
`else
    localparam logic [15:0] EXP_INSTR_CNT = 16'd0;
    localparam logic [15:0] EXP_STALL_CNT = 16'd0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              busy;
    logic [15:0]       perf_instr_cnt;
    logic [15:0]       perf_stall_cnt;
    logic [1:0]        dbg_state;

    code_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .busy           (busy),
        .perf_instr_cnt (perf_instr_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .dbg_state      (dbg_state)
    );

    // ---------------- code memory model ----------------
    logic [DATA_W-1:0] mem [512];
    always @(posedge clk) mem_data <= mem[mem_addr];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_instr(input string name, input logic [ADDR_W-1:0] pc);
        check({name, "_valid"}, 32'(instr_valid), 32'd1);
        check({name, "_pc"}, 32'(instr_pc), 32'(pc));
        check({name, "_data"}, 32'(instr_data), 32'(pc) + 32'h1000);
    endtask

    typedef struct {
        logic              rdy;
        logic              rv;
        logic [ADDR_W-1:0] rpc;
        logic              hlt;
        logic              e_valid;
        logic [ADDR_W-1:0] e_pc;
        logic [DATA_W-1:0] e_data;
        logic              e_busy;
        logic [ADDR_W-1:0] e_addr;
        logic [1:0]        e_st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [ADDR_W-1:0] rpc,
                                input logic hlt, input logic ev, input logic [ADDR_W-1:0] epc,
                                input logic [DATA_W-1:0] edata, input logic eb,
                                input logic [ADDR_W-1:0] ea, input logic [1:0] est);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hlt = hlt;
        v.e_valid = ev; v.e_pc = epc; v.e_data = edata; v.e_busy = eb;
        v.e_addr = ea; v.e_st = est;
        return v;
    endfunction

    // Watchdog: the sequence is fixed-length, this only guards a hung simulator.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'(i) + 16'h1000;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;

        //            rdy rv rpc    hlt  ev  pc     data     busy addr  st
        vecs.push_back(mk(1, 0, 9'h000, 0, 0, 9'h000, 16'h0000, 0, 9'h000, 2'd0)); // C0 first issue
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h000, 16'h1000, 1, 9'h001, 2'd0)); // C1 first valid
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h001, 16'h1001, 1, 9'h002, 2'd0));
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h002, 16'h1002, 1, 9'h003, 2'd0));
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h003, 16'h1003, 1, 9'h004, 2'd0));
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h004, 16'h1004, 1, 9'h005, 2'd0));
        vecs.push_back(mk(0, 0, 9'h000, 0, 1, 9'h005, 16'h1005, 1, 9'h005, 2'd0)); // C6 stall
        vecs.push_back(mk(0, 0, 9'h000, 0, 1, 9'h005, 16'h1005, 1, 9'h005, 2'd0));
        vecs.push_back(mk(0, 0, 9'h000, 0, 1, 9'h005, 16'h1005, 1, 9'h005, 2'd0));
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h005, 16'h1005, 1, 9'h006, 2'd0)); // release
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h006, 16'h1006, 1, 9'h007, 2'd0)); // no bubble
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h007, 16'h1007, 1, 9'h008, 2'd0));
        vecs.push_back(mk(0, 0, 9'h000, 1, 1, 9'h008, 16'h1008, 1, 9'h008, 2'd0)); // C12 halt+stall
        vecs.push_back(mk(0, 0, 9'h000, 1, 1, 9'h008, 16'h1008, 1, 9'h008, 2'd1)); // drain
        vecs.push_back(mk(1, 0, 9'h000, 1, 1, 9'h008, 16'h1008, 1, 9'h009, 2'd1)); // pc8 fires
        vecs.push_back(mk(1, 0, 9'h000, 1, 0, 9'h000, 16'h0000, 0, 9'h009, 2'd2)); // halted
        vecs.push_back(mk(1, 0, 9'h000, 1, 0, 9'h000, 16'h0000, 0, 9'h009, 2'd2));
        vecs.push_back(mk(1, 0, 9'h000, 0, 0, 9'h000, 16'h0000, 0, 9'h009, 2'd2)); // halt drops
        vecs.push_back(mk(1, 0, 9'h000, 0, 0, 9'h000, 16'h0000, 0, 9'h009, 2'd0)); // issue 9
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h009, 16'h1009, 1, 9'h00A, 2'd0));
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h00A, 16'h100A, 1, 9'h00B, 2'd0));
        vecs.push_back(mk(1, 1, 9'h1FF, 0, 0, 9'h000, 16'h0000, 1, 9'h1FF, 2'd0)); // C21 redirect 511
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h1FF, 16'h11FF, 1, 9'h000, 2'd0)); // wrap
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h000, 16'h1000, 1, 9'h001, 2'd0));
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h001, 16'h1001, 1, 9'h002, 2'd0));
        vecs.push_back(mk(0, 0, 9'h000, 0, 1, 9'h002, 16'h1002, 1, 9'h002, 2'd0)); // stall
        vecs.push_back(mk(0, 1, 9'h100, 0, 0, 9'h000, 16'h0000, 1, 9'h100, 2'd0)); // redirect in stall
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h100, 16'h1100, 1, 9'h101, 2'd0));
        vecs.push_back(mk(1, 0, 9'h000, 1, 1, 9'h101, 16'h1101, 1, 9'h102, 2'd0)); // halt with fire
        vecs.push_back(mk(1, 1, 9'h050, 1, 0, 9'h000, 16'h0000, 0, 9'h050, 2'd2)); // redirect halted
        vecs.push_back(mk(1, 0, 9'h000, 0, 0, 9'h000, 16'h0000, 0, 9'h050, 2'd2));
        vecs.push_back(mk(1, 0, 9'h000, 0, 0, 9'h000, 16'h0000, 0, 9'h050, 2'd0));
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h050, 16'h1050, 1, 9'h051, 2'd0));
        vecs.push_back(mk(0, 0, 9'h000, 1, 1, 9'h051, 16'h1051, 1, 9'h051, 2'd0)); // drain entry
        vecs.push_back(mk(0, 0, 9'h000, 0, 1, 9'h051, 16'h1051, 1, 9'h051, 2'd1)); // halt drops in drain
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h051, 16'h1051, 1, 9'h052, 2'd0));
        vecs.push_back(mk(1, 0, 9'h000, 0, 1, 9'h052, 16'h1052, 1, 9'h053, 2'd0));

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_perf_instr", 32'(perf_instr_cnt), 32'd0);
        check("rst_perf_stall", 32'(perf_stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors, one per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            instr_ready    = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            halt           = vecs[i].hlt;
            #1;
            check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_state", i), 32'(dbg_state), 32'(vecs[i].e_st));
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_pc", i), 32'(instr_pc), 32'(vecs[i].e_pc));
                check($sformatf("v%0d_data", i), 32'(instr_data), 32'(vecs[i].e_data));
            end
            @(negedge clk);
        end

        // Mid-stream reset at pc 40
        instr_ready    = 1'b1;
        halt           = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 9'd30;
        #1;
        check("redir30_valid", 32'(instr_valid), 32'd0);
        check("redir30_addr", 32'(mem_addr), 32'd30);
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 30; k <= 40; k++) begin
            #1;
            check_instr($sformatf("seq%0d", k), 9'(k));
            if (k != 40) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        check("midrst_perf_instr", 32'(perf_instr_cnt), 32'd0);
        check("midrst_perf_stall", 32'(perf_stall_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("restart_valid", 32'(instr_valid), 32'd0);
        check("restart_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_instr($sformatf("restart%0d", k), 9'(k));
            @(negedge clk);
        end

        // Redirect squashes pc 3
        redirect_valid = 1'b1;
        redirect_pc    = 9'h1F0;
        #1;
        check("squash3_valid", 32'(instr_valid), 32'd0);
        check("squash3_pc", 32'(instr_pc), 32'd3);
        check("squash3_addr", 32'(mem_addr), 32'h1F0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check_instr("tgt1F0", 9'h1F0);
        @(negedge clk);
        #1;
        check_instr("tgt1F1", 9'h1F1);
        @(negedge clk);

        // Three stall cycles then a burst, for the counters
        instr_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check_instr($sformatf("hold%0d", s), 9'h1F2);
            check($sformatf("hold%0d_addr", s), 32'(mem_addr), 32'h1F2);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        for (int k = 'h1F2; k <= 'h200; k++) begin
            #1;
            check_instr($sformatf("burst%0h", k), 9'(k));
            @(negedge clk);
        end
        instr_ready = 1'b0;
        #1;
        check("perf_instr", 32'(perf_instr_cnt), 32'(EXP_INSTR_CNT));
        check("perf_stall", 32'(perf_stall_cnt), 32'(EXP_STALL_CNT));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
